// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped write-back data cache.
package cache_pkg;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int NUM_LINES  = 8;
    localparam int LINE_WORDS = 4;
    localparam int TAG_W      = 7;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;
endpackage

// File: rtl/cache_if.sv
// Core-side data port of the cache: the core drives the request, the cache answers.
interface cache_if;
    import cache_pkg::*;

    logic              CACHE_CSN;
    logic              CACHE_WEN;
    logic [ADDR_W-1:0] CACHE_ADDR;
    logic [DATA_W-1:0] CACHE_DI;
    logic [DATA_W-1:0] CACHE_DOUT;
    logic              CACHE_MISS;

    modport master (
        output CACHE_CSN, CACHE_WEN, CACHE_ADDR, CACHE_DI,
        input  CACHE_DOUT, CACHE_MISS
    );

    modport slave (
        input  CACHE_CSN, CACHE_WEN, CACHE_ADDR, CACHE_DI,
        output CACHE_DOUT, CACHE_MISS
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller: write-back and line-fill sequencing plus SRAM-side signalling.
module cache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req_miss,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wb_word,
    output logic              idle,
    output logic              replay,
    output logic [OFF_W-1:0]  beat_off,
    output logic              fill_we,
    output logic [OFF_W-1:0]  fill_off,
    output logic              fill_done,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [DATA_W-1:0] D_MEM_DOUT
);
    state_t     state, state_nx;
    logic [2:0] beat, beat_nx;
    logic       replay_nx;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state  <= IDLE;
            beat   <= '0;
            replay <= 1'b0;
        end else begin
            state  <= state_nx;
            beat   <= beat_nx;
            replay <= replay_nx;
        end
    end

    assign idle       = (state == IDLE);
    assign beat_off   = beat[1:0];
    // SRAM data lags its address by one cycle, so beat k captures word k-1
    assign fill_off   = beat[1:0] - 2'd1;
    assign D_MEM_DOUT = wb_word;

    always_comb begin
        state_nx   = state;
        beat_nx    = beat;
        replay_nx  = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        D_MEM_CSN  = 1'b1;
        D_MEM_WEN  = 1'b1;
        D_MEM_ADDR = '0;
        case (state)
            IDLE: begin
                if (req_miss) begin
                    state_nx = victim_dirty ? WB : FILL;
                    beat_nx  = '0;
                end
            end
            WB: begin
                D_MEM_CSN  = 1'b0;
                D_MEM_WEN  = 1'b0;
                D_MEM_ADDR = {victim_tag, idx, beat[1:0]};
                if (beat == 3'd3) begin
                    state_nx = FILL;
                    beat_nx  = '0;
                end else begin
                    beat_nx = beat + 3'd1;
                end
            end
            FILL: begin
                fill_we = (beat != 3'd0);
                if (beat == 3'd4) begin
                    fill_done = 1'b1;
                    replay_nx = 1'b1;
                    state_nx  = IDLE;
                    beat_nx   = '0;
                end else begin
                    D_MEM_CSN  = 1'b0;
                    D_MEM_ADDR = {req_tag, idx, beat[1:0]};
                    beat_nx    = beat + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                beat_nx  = '0;
            end
        endcase
        if (!RSTn) begin
            D_MEM_CSN = 1'b1;
            D_MEM_WEN = 1'b1;
        end
    end
endmodule

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate data cache between the core data port and the data SRAM.
module cache
    import cache_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    cache_if.slave            bus,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [3:0]        D_MEM_BE,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [DATA_W-1:0] D_MEM_DOUT,
    input  logic [DATA_W-1:0] D_MEM_DI,
    output logic [31:0]       hitnum,
    output logic [31:0]       missnum
);
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [DATA_W-1:0]    data_arr [NUM_LINES][LINE_WORDS];

    logic              req, hit, idle, replay;
    logic              acc_hit, miss_req;
    logic [OFF_W-1:0]  beat_off, fill_off;
    logic              fill_we, fill_done;

    assign {req_tag, idx, off} = bus.CACHE_ADDR;
    assign req      = !bus.CACHE_CSN;
    assign hit      = valid[idx] && (tag_arr[idx] == req_tag);
    assign acc_hit  = idle && req && hit;
    assign miss_req = idle && req && !hit;
    assign D_MEM_BE = 4'b1111;

    assign bus.CACHE_DOUT = data_arr[idx][off];
    assign bus.CACHE_MISS = RSTn && ((req && !hit) || !idle);

    cache_ctrl_fsm u_ctrl (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .req_miss     (req && !hit),
        .victim_dirty (valid[idx] && dirty[idx]),
        .req_tag      (req_tag),
        .victim_tag   (tag_arr[idx]),
        .idx          (idx),
        .wb_word      (data_arr[idx][beat_off]),
        .idle         (idle),
        .replay       (replay),
        .beat_off     (beat_off),
        .fill_we      (fill_we),
        .fill_off     (fill_off),
        .fill_done    (fill_done),
        .D_MEM_CSN    (D_MEM_CSN),
        .D_MEM_WEN    (D_MEM_WEN),
        .D_MEM_ADDR   (D_MEM_ADDR),
        .D_MEM_DOUT   (D_MEM_DOUT)
    );

    // The replayed access after a fill is the tail of a miss, not a new hit
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            valid   <= '0;
            dirty   <= '0;
            hitnum  <= '0;
            missnum <= '0;
        end else begin
            if (acc_hit && !replay)
                hitnum <= hitnum + 32'd1;
            if (miss_req)
                missnum <= missnum + 32'd1;
            if (acc_hit && !bus.CACHE_WEN)
                dirty[idx] <= 1'b1;
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (acc_hit && !bus.CACHE_WEN)
            data_arr[idx][off] <= bus.CACHE_DI;
        if (fill_we)
            data_arr[idx][fill_off] <= D_MEM_DI;
        if (fill_done)
            tag_arr[idx] <= req_tag;
    end
endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for the data cache with a 1-cycle synchronous SRAM model behind it.
module tb_cache;
    import cache_pkg::*;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              D_MEM_CSN, D_MEM_WEN;
    logic [3:0]        D_MEM_BE;
    logic [ADDR_W-1:0] D_MEM_ADDR;
    logic [DATA_W-1:0] D_MEM_DOUT;
    logic [DATA_W-1:0] D_MEM_DI;
    logic [31:0]       hitnum, missnum;

    cache_if bus();

    cache dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .bus        (bus),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_BE   (D_MEM_BE),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_DI   (D_MEM_DI),
        .hitnum     (hitnum),
        .missnum    (missnum)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] mem     [0:4095];
    logic [DATA_W-1:0] ref_mem [0:4095];
    logic [DATA_W-1:0] init_val[0:4095];
    logic [ADDR_W-1:0] log_addr[$];
    logic              log_wr  [$];
    logic [DATA_W-1:0] log_data[$];
    logic [DATA_W-1:0] exp_q   [$];

    int n_chk  = 0;
    int n_pass = 0;

    always @(posedge CLK) begin
        if (!D_MEM_CSN) begin
            if (!D_MEM_WEN)
                mem[D_MEM_ADDR] <= D_MEM_DOUT;
            D_MEM_DI <= mem[D_MEM_ADDR];
            log_addr.push_back(D_MEM_ADDR);
            log_wr.push_back(!D_MEM_WEN);
            log_data.push_back(D_MEM_DOUT);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issues one access and holds it until CACHE_MISS drops; stall excludes the issuing cycle
    task automatic access(input logic wr, input logic [11:0] a, input logic [31:0] d, output int stall);
        int hi;
        logic [31:0] exp;
        @(negedge CLK);
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
        bus.CACHE_CSN  = 1'b0;
        bus.CACHE_WEN  = ~wr;
        bus.CACHE_ADDR = a;
        bus.CACHE_DI   = d;
        if (wr) ref_mem[a] = d;
        else    exp_q.push_back(ref_mem[a]);
        #1;
        hi = 0;
        while (bus.CACHE_MISS && hi < 40) begin
            hi++;
            @(negedge CLK);
            #1;
        end
        if (bus.CACHE_MISS)
            check_eq($sformatf("timeout_%03h", a), 32'(bus.CACHE_MISS), 32'd0);
        stall = (hi > 0) ? hi - 1 : 0;
        if (!wr) begin
            exp = exp_q.pop_front();
            check_eq($sformatf("rdata_%03h", a), bus.CACHE_DOUT, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        bus.CACHE_CSN = 1'b1;
        bus.CACHE_WEN = 1'b1;
        #1;
    endtask

    task automatic check_log(input string name, input logic wb, input logic [11:0] wb_base,
                             input logic [11:0] fill_base);
        int p = 0;
        check_eq({name, "_memops"}, 32'(log_addr.size()), wb ? 32'd8 : 32'd4);
        if (wb) begin
            for (int k = 0; k < 4; k++) begin
                if (p < log_addr.size()) begin
                    check_eq($sformatf("%s_wb%0d_addr", name, k), 32'(log_addr[p]), 32'(wb_base + 12'(k)));
                    check_eq($sformatf("%s_wb%0d_wr", name, k), 32'(log_wr[p]), 32'd1);
                    check_eq($sformatf("%s_wb%0d_data", name, k), log_data[p], ref_mem[wb_base + 12'(k)]);
                end
                p++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (p < log_addr.size()) begin
                check_eq($sformatf("%s_fill%0d_addr", name, k), 32'(log_addr[p]), 32'(fill_base + 12'(k)));
                check_eq($sformatf("%s_fill%0d_wr", name, k), 32'(log_wr[p]), 32'd0);
            end
            p++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        for (int i = 0; i < 4096; i++) init_val[i] = 32'hC000_0000 | (i * 7);
        init_val[12'h010] = 32'h0000_1234;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = init_val[i];
            ref_mem[i] = init_val[i];
        end
        RSTn           = 1'b0;
        bus.CACHE_CSN  = 1'b1;
        bus.CACHE_WEN  = 1'b1;
        bus.CACHE_ADDR = '0;
        bus.CACHE_DI   = '0;

        // Reset
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_eq("rst_miss", 32'(bus.CACHE_MISS), 32'd0);
        check_eq("rst_mem_csn", 32'(D_MEM_CSN), 32'd1);
        check_eq("rst_mem_wen", 32'(D_MEM_WEN), 32'd1);
        check_eq("mem_be", 32'(D_MEM_BE), 32'hF);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check_eq("rst_hitnum", hitnum, 32'd0);
        check_eq("rst_missnum", missnum, 32'd0);

        // Clean read miss
        access(1'b0, 12'h010, 32'h0, st);
        check_eq("stall_010", 32'(st), 32'd5);
        check_log("miss_010", 1'b0, 12'h000, 12'h010);
        idle_cycle();
        check_eq("missnum_1", missnum, 32'd1);
        check_eq("hitnum_0", hitnum, 32'd0);

        // Back-to-back read hits
        access(1'b0, 12'h011, 32'h0, st);
        check_eq("stall_011", 32'(st), 32'd0);
        access(1'b0, 12'h013, 32'h0, st);
        check_eq("stall_013", 32'(st), 32'd0);
        idle_cycle();
        check_eq("hitnum_2", hitnum, 32'd2);

        // Write hit then read back; SRAM keeps the old word
        access(1'b1, 12'h012, 32'h0000_ABCD, st);
        check_eq("stall_wr012", 32'(st), 32'd0);
        access(1'b0, 12'h012, 32'h0, st);
        idle_cycle();
        check_eq("sram_012_stale", mem[12'h012], init_val[12'h012]);
        check_eq("hitnum_4", hitnum, 32'd4);

        // Dirty conflict miss
        access(1'b0, 12'h112, 32'h0, st);
        check_eq("stall_112", 32'(st), 32'd9);
        check_log("miss_112", 1'b1, 12'h010, 12'h110);
        idle_cycle();
        check_eq("sram_012_wb", mem[12'h012], 32'h0000_ABCD);
        check_eq("missnum_2", missnum, 32'd2);

        // Write miss allocates, replay writes, no hit counted
        access(1'b1, 12'h200, 32'h5555_5555, st);
        check_eq("stall_wr200", 32'(st), 32'd5);
        check_log("miss_200", 1'b0, 12'h000, 12'h200);
        idle_cycle();
        check_eq("hitnum_after_wmiss", hitnum, 32'd4);
        check_eq("missnum_3", missnum, 32'd3);
        access(1'b0, 12'h200, 32'h0, st);
        check_eq("stall_rd200", 32'(st), 32'd0);
        access(1'b0, 12'h000, 32'h0, st);
        check_eq("stall_000", 32'(st), 32'd9);
        check_log("miss_000", 1'b1, 12'h200, 12'h000);
        idle_cycle();
        check_eq("hitnum_5", hitnum, 32'd5);
        check_eq("missnum_4", missnum, 32'd4);

        // 0x112 is cached; reset in the middle of a fill must forget it
        access(1'b0, 12'h112, 32'h0, st);
        check_eq("stall_112_hit", 32'(st), 32'd0);
        @(negedge CLK);
        bus.CACHE_CSN  = 1'b0;
        bus.CACHE_WEN  = 1'b1;
        bus.CACHE_ADDR = 12'h3A0;
        #1;
        check_eq("miss_3a0", 32'(bus.CACHE_MISS), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_eq("in_fill_csn", 32'(D_MEM_CSN), 32'd0);
        @(negedge CLK);
        RSTn          = 1'b0;
        bus.CACHE_CSN = 1'b1;
        #1;
        check_eq("midrst_miss", 32'(bus.CACHE_MISS), 32'd0);
        check_eq("midrst_mem_csn", 32'(D_MEM_CSN), 32'd1);
        check_eq("midrst_mem_wen", 32'(D_MEM_WEN), 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check_eq("postrst_miss", 32'(bus.CACHE_MISS), 32'd0);
        check_eq("postrst_mem_csn", 32'(D_MEM_CSN), 32'd1);
        check_eq("postrst_hitnum", hitnum, 32'd0);
        check_eq("postrst_missnum", missnum, 32'd0);
        access(1'b0, 12'h112, 32'h0, st);
        check_eq("stall_112_again", 32'(st), 32'd5);
        idle_cycle();
        check_eq("postrst_missnum_1", missnum, 32'd1);
        check_eq("postrst_hitnum_0", hitnum, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
